vram_write_arbiter: RTL

Sequences every write into the 320x240 12-bit frame buffer. Arbitrates two pixel-write requesters (e.g. game logic and sprite drawer) round-robin with a valid/ready handshake. Contains a frame-clear engine that sweeps all 76800 pixels with one colour. Drives the buffer's write side (i, j, wval, rw) from registered outputs; the buffer's read side is untouched.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_rr_arbiter.sv | 40 ++++
 rtl/vram_write_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared frame-buffer geometry, vertical active window and arbiter FSM state codes.
// Used by the video RAM, the VGA timing block and vram_write_arbiter.
package vram_pkg;

  localparam int H_RES      = 320;
  localparam int V_RES      = 240;
  localparam int COLOR_W    = 12;
  localparam int VACT_START = 35;
  localparam int VACT_END   = 515;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic logic in_frame(input logic [8:0] row, input logic [8:0] col);
    return (row < 9'(V_RES)) && (col < 9'(H_RES));
  endfunction

endpackage

// File: rtl/vram_rr_arbiter.sv
// Two-way round-robin grant. A tie goes to the requester that did not win the last
// transfer; r_last_grant resets to 1 so requester 0 wins the first tie.
module vram_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_last_grant;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = r_last_grant;
        o_gnt1 = ~r_last_grant;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  // A grant is only ever given to a valid requester, so every grant is a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (o_gnt0) begin
      r_last_grant <= 1'b0;
    end else if (o_gnt1) begin
      r_last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Frame-buffer write sequencer: round-robin pixel requesters plus a full-frame clear sweep.
// Define VBLANK_ONLY_EN to restrict writes to the vertical blanking interval (VCV window).
//
// Handshake: a requester transfers in any cycle where valid && ready; ready is combinational,
// at most one ready is high per cycle, and both are low during CLEAR or on a clear_start cycle.
module vram_write_arbiter
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        VCV,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [8:0]         r0_i,
  input  logic [8:0]         r0_j,
  input  logic [COLOR_W-1:0] r0_color,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [8:0]         r1_i,
  input  logic [8:0]         r1_j,
  input  logic [COLOR_W-1:0] r1_color,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [8:0]         i,
  output logic [8:0]         j,
  output logic [COLOR_W-1:0] wval,
  output logic               rw,
  output logic [7:0]         drop_cnt
);

  logic [0:0]         r_state;
  logic [8:0]         r_row;
  logic [8:0]         r_col;
  logic [COLOR_W-1:0] r_clear_color;
  logic               r_last;

  logic               w_vactive;
  logic               w_serve;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_xfer;
  logic [8:0]         w_sel_i;
  logic [8:0]         w_sel_j;
  logic [COLOR_W-1:0] w_sel_c;
  logic               w_row_end;
  logic               w_last_pix;

`ifdef VBLANK_ONLY_EN
  assign w_vactive = (VCV >= 16'(VACT_START)) && (VCV < 16'(VACT_END));
`else
  // VCV is read here only so the port is not dangling; the result is always 0.
  assign w_vactive = 1'b0 & (|VCV);
`endif

  assign w_serve = (r_state == ST_IDLE) && !clear_start && !w_vactive;

  vram_rr_arbiter u_rr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_serve),
    .i_req0 (r0_valid),
    .i_req1 (r1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign r0_ready   = w_gnt0;
  assign r1_ready   = w_gnt1;
  assign w_xfer     = w_gnt0 | w_gnt1;
  assign w_sel_i    = w_gnt1 ? r1_i : r0_i;
  assign w_sel_j    = w_gnt1 ? r1_j : r0_j;
  assign w_sel_c    = w_gnt1 ? r1_color : r0_color;
  assign w_row_end  = (r_col == 9'(H_RES - 1));
  assign w_last_pix = w_row_end && (r_row == 9'(V_RES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_row         <= '0;
      r_col         <= '0;
      r_clear_color <= '0;
      r_last        <= 1'b0;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
      i             <= '0;
      j             <= '0;
      wval          <= '0;
      rw            <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      rw         <= 1'b0;
      clear_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear_start) begin
            r_state       <= ST_CLEAR;
            clear_busy    <= 1'b1;
            r_clear_color <= clear_color;
            r_row         <= '0;
            r_col         <= '0;
            r_last        <= 1'b0;
          end else if (w_xfer) begin
            if (in_frame(w_sel_i, w_sel_j)) begin
              rw   <= 1'b1;
              i    <= w_sel_i;
              j    <= w_sel_j;
              wval <= w_sel_c;
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
        end
        ST_CLEAR: begin
          // r_last marks the cycle in which the final pixel is on the bus; done follows it.
          if (r_last) begin
            r_state    <= ST_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            r_last     <= 1'b0;
          end else if (!w_vactive) begin
            rw   <= 1'b1;
            i    <= r_row;
            j    <= r_col;
            wval <= r_clear_color;
            if (w_last_pix) begin
              r_last <= 1'b1;
            end else if (w_row_end) begin
              r_col <= '0;
              r_row <= r_row + 9'd1;
            end else begin
              r_col <= r_col + 9'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
